// File: rtl/direction_ram_tb_engine_if.sv
// Bus bundle for the direction store: external RAM port, init/traceback controls
// and the traceback output stream.
interface direction_ram_tb_engine_if #(
  parameter int unsigned N     = 5,
  parameter int unsigned DIR_W = 3
);
  localparam int unsigned DEPTH  = (N + 1) * (N + 1);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W  = $clog2(N + 1);

  logic [DIR_W-1:0]  din;
  logic              en_din;
  logic              we;
  logic [ADDR_W-1:0] addr_din;
  logic              en_dout;
  logic [ADDR_W-1:0] addr_dout;
  logic [DIR_W-1:0]  dout;
  logic              init_start;
  logic              tb_start;
  logic              busy;
  logic              tb_valid;
  logic [DIR_W-1:0]  tb_dir;
  logic [IDX_W-1:0]  tb_row;
  logic [IDX_W-1:0]  tb_col;
  logic              tb_done;
  logic              tb_err;

  modport master (
    output din, en_din, we, addr_din, en_dout, addr_dout, init_start, tb_start,
    input  dout, busy, tb_valid, tb_dir, tb_row, tb_col, tb_done, tb_err
  );

  modport slave (
    input  din, en_din, we, addr_din, en_dout, addr_dout, init_start, tb_start,
    output dout, busy, tb_valid, tb_dir, tb_row, tb_col, tb_done, tb_err
  );
endinterface

// File: rtl/direction_ram_tb_engine.sv
// NW direction matrix store with a boundary-init sequencer and a traceback walker
// that streams the alignment path from (N,N) back to the origin.
module direction_ram_tb_engine #(
  parameter int unsigned N     = 5,
  parameter int unsigned DIR_W = 3
) (
  input logic                      clk,
  input logic                      rst,
  direction_ram_tb_engine_if.slave bus
);
  localparam int unsigned DEPTH  = (N + 1) * (N + 1);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W  = $clog2(N + 1);
  localparam int unsigned CNT_W  = IDX_W + 1;

  localparam logic [DIR_W-1:0] DirNone = DIR_W'(0);
  localparam logic [DIR_W-1:0] DirDiag = DIR_W'(1);
  localparam logic [DIR_W-1:0] DirUp   = DIR_W'(2);
  localparam logic [DIR_W-1:0] DirLeft = DIR_W'(4);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StInit = 3'd1;
  localparam logic [2:0] StTbRd = 3'd2;
  localparam logic [2:0] StTbEv = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [DIR_W-1:0]  mem_q [DEPTH];
  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  r_q, r_d, c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIR_W-1:0]  dout_q, dout_d;
  logic [DIR_W-1:0]  tb_dir_q, tb_dir_d;
  logic [IDX_W-1:0]  tb_row_q, tb_row_d, tb_col_q, tb_col_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DIR_W-1:0]  wr_data;
  logic [ADDR_W-1:0] tb_addr;
  logic              tb_valid, tb_done, tb_err;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  assign tb_addr = ADDR_W'(r_q) * ADDR_W'(N + 1) + ADDR_W'(c_q);

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    tb_dir_d = tb_dir_q;
    tb_row_d = tb_row_q;
    tb_col_d = tb_col_q;
    wr_en    = 1'b0;
    wr_addr  = bus.addr_din;
    wr_data  = bus.din;
    tb_valid = 1'b0;
    tb_done  = 1'b0;
    tb_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        wr_en = bus.en_din && bus.we && in_range(bus.addr_din);
        // mem_q still holds the pre-write value here, giving read-first behaviour
        if (bus.en_dout) begin
          dout_d = in_range(bus.addr_dout) ? mem_q[bus.addr_dout] : '0;
        end
        if (bus.init_start) begin
          state_d = StInit;
          cnt_d   = '0;
        end else if (bus.tb_start) begin
          state_d = StTbRd;
          r_d     = IDX_W'(N);
          c_d     = IDX_W'(N);
        end
      end
      StInit: begin
        wr_en = 1'b1;
        if (cnt_q == '0) begin
          wr_addr = '0;
          wr_data = DirNone;
        end else if (cnt_q <= CNT_W'(N)) begin
          wr_addr = ADDR_W'(cnt_q);
          wr_data = DirLeft;
        end else begin
          wr_addr = ADDR_W'(cnt_q - CNT_W'(N)) * ADDR_W'(N + 1);
          wr_data = DirUp;
        end
        if (cnt_q == CNT_W'(2 * N)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StTbRd: begin
        tb_dir_d = mem_q[tb_addr];
        tb_row_d = r_q;
        tb_col_d = c_q;
        state_d  = StTbEv;
      end
      StTbEv: begin
        tb_valid = 1'b1;
        state_d  = StTbRd;
        if (r_q == '0 && c_q == '0) begin
          tb_done = 1'b1;
          state_d = StDone;
        end else begin
          case (tb_dir_q)
            DirDiag: begin
              if (r_q == '0 || c_q == '0) begin
                tb_err = 1'b1;
              end else begin
                r_d = r_q - IDX_W'(1);
                c_d = c_q - IDX_W'(1);
              end
            end
            DirUp: begin
              if (r_q == '0) tb_err = 1'b1;
              else           r_d = r_q - IDX_W'(1);
            end
            DirLeft: begin
              if (c_q == '0) tb_err = 1'b1;
              else           c_d = c_q - IDX_W'(1);
            end
            default: tb_err = 1'b1;
          endcase
          if (tb_err) state_d = StIdle;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      r_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      tb_dir_q <= '0;
      tb_row_q <= '0;
      tb_col_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      tb_dir_q <= tb_dir_d;
      tb_row_q <= tb_row_d;
      tb_col_q <= tb_col_d;
    end
  end

  // Contents survive reset; only the write gating depends on it.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign bus.dout     = dout_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.tb_valid = tb_valid;
  assign bus.tb_dir   = tb_dir_q;
  assign bus.tb_row   = tb_row_q;
  assign bus.tb_col   = tb_col_q;
  assign bus.tb_done  = tb_done;
  assign bus.tb_err   = tb_err;
endmodule

// File: tb/tb_direction_ram_tb_engine.sv
// Bench for direction_ram_tb_engine: directed steps plus randomized matrices
// checked against a path model walking the stored directions.
module tb_direction_ram_tb_engine;
  localparam int N     = 5;
  localparam int DIR_W = 3;
  localparam int ROW   = N + 1;
  localparam int DEPTH = ROW * ROW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  direction_ram_tb_engine_if #(.N(N), .DIR_W(DIR_W)) bus ();

  direction_ram_tb_engine #(.N(N), .DIR_W(DIR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int dir;
    int row;
    int col;
    bit err;
    bit done;
  } step_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    model_mem [DEPTH];
  step_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.din        = '0;
    bus.en_din     = 1'b0;
    bus.we         = 1'b0;
    bus.addr_din   = '0;
    bus.en_dout    = 1'b0;
    bus.addr_dout  = '0;
    bus.init_start = 1'b0;
    bus.tb_start   = 1'b0;
  endtask

  task automatic write_cell(input int addr, input int data, input bit upd);
    bus.en_din   = 1'b1;
    bus.we       = 1'b1;
    bus.addr_din = addr[5:0];
    bus.din      = data[2:0];
    @(negedge clk);
    bus.en_din = 1'b0;
    bus.we     = 1'b0;
    if (upd && addr < DEPTH) model_mem[addr] = data;
  endtask

  task automatic read_check(input int addr, input string tag);
    bus.en_dout   = 1'b1;
    bus.addr_dout = addr[5:0];
    @(negedge clk);
    bus.en_dout = 1'b0;
    check(tag, 32'(bus.dout), (addr < DEPTH) ? model_mem[addr] : 0);
  endtask

  function automatic void model_init();
    model_mem[0] = 0;
    for (int k = 1; k <= N; k++) begin
      model_mem[k]       = 4;
      model_mem[k * ROW] = 2;
    end
  endfunction

  // Walk the stored directions from (N,N) by the move rules.
  function automatic void build_expected();
    int r = N;
    int c = N;
    int d;
    step_t s;
    exp_q.delete();
    for (int guard = 0; guard < 4 * N + 4; guard++) begin
      d = model_mem[r * ROW + c];
      s = '{dir: d, row: r, col: c, err: 1'b0, done: 1'b0};
      if (r == 0 && c == 0) begin
        s.done = 1'b1;
        exp_q.push_back(s);
        break;
      end else if (d == 1 && r > 0 && c > 0) begin
        r--; c--;
      end else if (d == 2 && r > 0) begin
        r--;
      end else if (d == 4 && c > 0) begin
        c--;
      end else begin
        s.err = 1'b1;
        exp_q.push_back(s);
        break;
      end
      exp_q.push_back(s);
    end
  endfunction

  task automatic run_init(input string tag);
    int cnt = 0;
    bus.init_start = 1'b1;
    @(negedge clk);
    bus.init_start = 1'b0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cnt, 11);
    model_init();
  endtask

  task automatic run_tb(input string tag);
    int    total;
    int    seen = 0;
    int    cyc  = 1;
    int    last_dir = 0;
    int    w = 0;
    bit    fin = 1'b0;
    step_t e;
    build_expected();
    total = exp_q.size();
    bus.tb_start = 1'b1;
    @(negedge clk);
    bus.tb_start = 1'b0;
    while (!fin && cyc < 200) begin
      if (bus.tb_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_strobe"}, seen, total);
          fin = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check({tag, "_dir"}, 32'(bus.tb_dir), e.dir);
          check({tag, "_row"}, 32'(bus.tb_row), e.row);
          check({tag, "_col"}, 32'(bus.tb_col), e.col);
          check({tag, "_done"}, 32'(bus.tb_done), 32'(e.done));
          check({tag, "_err"}, 32'(bus.tb_err), 32'(e.err));
          check({tag, "_strobe_cycle"}, cyc, 2 * seen);
          last_dir = e.dir;
          if (e.done || e.err) fin = 1'b1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_finished"}, 32'(fin), 1);
    check({tag, "_cells"}, seen, total);
    @(negedge clk);
    while (bus.busy && w < 5) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_idle_after"}, 32'(bus.busy), 0);
    check({tag, "_dir_hold"}, 32'(bus.tb_dir), last_dir);
  endtask

  initial begin
    int cnt;
    int vcnt;
    int v;
    int bad [5] = '{0, 3, 5, 6, 7};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.tb_valid), 0);
    check("rst_done", 32'(bus.tb_done), 0);
    check("rst_err", 32'(bus.tb_err), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_tb_row", 32'(bus.tb_row), 0);
    check("rst_tb_col", 32'(bus.tb_col), 0);
    check("rst_tb_dir", 32'(bus.tb_dir), 0);
    rst = 1'b0;
    @(negedge clk);

    // External write / read-back
    write_cell(0, 1, 1'b1);
    write_cell(1, 2, 1'b1);
    write_cell(2, 4, 1'b1);
    read_check(0, "rd0");
    read_check(1, "rd1");
    read_check(2, "rd2");

    // Same-address read and write: old data returned
    bus.en_din = 1'b1; bus.we = 1'b1; bus.addr_din = 6'd1; bus.din = 3'd4;
    bus.en_dout = 1'b1; bus.addr_dout = 6'd1;
    @(negedge clk);
    idle_inputs();
    check("read_first", 32'(bus.dout), model_mem[1]);
    model_mem[1] = 4;
    read_check(1, "rd1_new");

    // dout holds with en_dout low
    @(negedge clk);
    check("dout_hold", 32'(bus.dout), 4);

    // Out-of-range write dropped, out-of-range read returns 0
    write_cell(40, 1, 1'b0);
    read_check(40, "rd_oob");
    read_check(2, "rd2_after_oob");

    // Boundary init
    run_init("init");
    read_check(0, "init_a0");
    read_check(3, "init_a3");
    read_check(18, "init_a18");

    // init_start with tb_start: init only
    write_cell(3, 1, 1'b1);
    bus.init_start = 1'b1;
    bus.tb_start   = 1'b1;
    @(negedge clk);
    idle_inputs();
    cnt = 0; vcnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      if (bus.tb_valid) vcnt++;
      @(negedge clk);
    end
    repeat (4) begin
      if (bus.tb_valid) vcnt++;
      @(negedge clk);
    end
    check("both_busy_cycles", cnt, 11);
    check("both_no_tb", vcnt, 0);
    model_init();
    read_check(3, "both_a3");

    // Diagonal path
    for (int k = 1; k <= N; k++) write_cell(k * ROW + k, 1, 1'b1);
    run_tb("diag");

    // Directed move sequence
    write_cell(5 * ROW + 5, 2, 1'b1);
    write_cell(4 * ROW + 5, 2, 1'b1);
    write_cell(3 * ROW + 5, 4, 1'b1);
    write_cell(3 * ROW + 4, 1, 1'b1);
    write_cell(2 * ROW + 3, 4, 1'b1);
    write_cell(2 * ROW + 2, 2, 1'b1);
    write_cell(1 * ROW + 2, 1, 1'b1);
    run_tb("moves");

    // UP on row 0 is an out-of-bounds move
    for (int r = 1; r <= N; r++) write_cell(r * ROW + 5, 2, 1'b1);
    write_cell(5, 2, 1'b1);
    run_tb("up_row0");
    run_init("reinit");

    // Randomized interiors
    for (int it = 0; it < 8; it++) begin
      for (int r = 1; r <= N; r++) begin
        for (int c = 1; c <= N; c++) begin
          v = int'($urandom_range(0, 15));
          if (v < 5)       v = 1;
          else if (v < 10) v = 2;
          else if (v < 15) v = 4;
          else             v = bad[$urandom_range(0, 4)];
          write_cell(r * ROW + c, v, 1'b1);
        end
      end
      run_tb("rand");
    end

    // NONE at (N,N): single error strobe
    write_cell(5 * ROW + 5, 0, 1'b1);
    run_tb("none_err");

    // Write during busy is dropped
    for (int k = 1; k <= N; k++) write_cell(k * ROW + k, 1, 1'b1);
    bus.init_start = 1'b1;
    @(negedge clk);
    bus.init_start = 1'b0;
    write_cell(14, 4, 1'b0);
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_wr_idle", 32'(bus.busy), 0);
    model_init();
    read_check(14, "busy_wr_dropped");

    // Reset mid-traceback
    read_check(3, "pre_rst_dout");
    bus.tb_start = 1'b1;
    @(negedge clk);
    bus.tb_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.tb_valid), 0);
    check("mid_rst_done", 32'(bus.tb_done), 0);
    check("mid_rst_err", 32'(bus.tb_err), 0);
    check("mid_rst_dout", 32'(bus.dout), 0);
    check("mid_rst_row", 32'(bus.tb_row), 0);
    read_check(0, "rst_keep_a0");
    read_check(3, "rst_keep_a3");
    read_check(7, "rst_keep_a7");
    read_check(18, "rst_keep_a18");
    read_check(35, "rst_keep_a35");
    run_tb("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
